// File: rtl/dmx_universe_store.sv
`default_nettype none
// ============================================================================
// dmx_universe_store : one DMX universe of channel values with slew-limited
//                      pan/tilt overlays for tracked fixtures
// Revision: 1.0
// ============================================================================
module dmx_universe_store #(
  parameter int NUM_FIXTURES = 2,
  parameter int ADDR_W       = 9,
  parameter int UNIVERSE     = 512,
  parameter int DATA_W       = 8,
  parameter int PARK_VALUE   = 128,
  parameter int SLEW_STEP    = 4,
  parameter int START_CODE   = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_W-1:0]              request_addr,
  input  logic                           request_pulse,
  output logic [ADDR_W-1:0]              addr_out,
  output logic [DATA_W-1:0]              data_out,
  output logic                           data_valid,
  input  logic                           wr_en,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [DATA_W-1:0]              wr_data,
  input  logic [NUM_FIXTURES*ADDR_W-1:0] pan_addr,
  input  logic [NUM_FIXTURES*ADDR_W-1:0] tilt_addr,
  input  logic [NUM_FIXTURES*DATA_W-1:0] pan,
  input  logic [NUM_FIXTURES*DATA_W-1:0] tilt,
  input  logic [NUM_FIXTURES-1:0]        calc_ready,
  input  logic                           frame_tick,
  output logic                           busy
);

  localparam int                DEPTH      = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   c_universe = (ADDR_W+1)'(UNIVERSE);
  localparam logic [ADDR_W-1:0] c_last     = ADDR_W'(UNIVERSE - 1);
  localparam logic [DATA_W-1:0] c_park     = DATA_W'(PARK_VALUE);
  localparam logic [DATA_W-1:0] c_start    = DATA_W'(START_CODE);
  localparam logic [DATA_W-1:0] c_step     = DATA_W'(SLEW_STEP);
  localparam logic [DATA_W:0]   c_step_x   = (DATA_W+1)'(SLEW_STEP);

  typedef enum logic [0:0] {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t                         state;
  logic [ADDR_W-1:0]              clr_cnt;
  logic [DATA_W-1:0]              ram [DEPTH];
  logic [NUM_FIXTURES*DATA_W-1:0] tgt_pan, tgt_tilt, cur_pan, cur_tilt;

  logic                           ram_we;
  logic [ADDR_W-1:0]              ram_waddr;
  logic [DATA_W-1:0]              ram_wdata;
  logic                           pan_hit, tilt_hit;
  logic [DATA_W-1:0]              pan_val, tilt_val, rd_val;

  // Distance is taken in DATA_W+1 signed bits so 250->5 walks down, never wraps.
  function automatic logic [DATA_W-1:0] slew(input logic [DATA_W-1:0] cur,
                                             input logic [DATA_W-1:0] tgt);
    logic signed [DATA_W:0] diff;
    logic        [DATA_W:0] mag;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag  = diff[DATA_W] ? $unsigned(-diff) : $unsigned(diff);
    if (SLEW_STEP == 0 || mag <= c_step_x) slew = tgt;
    else if (!diff[DATA_W])                slew = cur + c_step;
    else                                   slew = cur - c_step;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      busy    <= 1'b1;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == c_last) begin
        state <= RUN;
        busy  <= 1'b0;
      end
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_addr;
    ram_wdata = wr_data;
    if (state == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_cnt;
      ram_wdata = '0;
    end else if (wr_en && wr_addr != '0 && {1'b0, wr_addr} < c_universe) begin
      ram_we = 1'b1;
    end
    if (reset) ram_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  // Walk from the top index down so the lowest-index match wins.
  always_comb begin
    pan_hit  = 1'b0;
    tilt_hit = 1'b0;
    pan_val  = '0;
    tilt_val = '0;
    for (int i = NUM_FIXTURES - 1; i >= 0; i--) begin
      if (pan_addr[i*ADDR_W +: ADDR_W] != '0 && pan_addr[i*ADDR_W +: ADDR_W] == request_addr) begin
        pan_hit = 1'b1;
        pan_val = cur_pan[i*DATA_W +: DATA_W];
      end
      if (tilt_addr[i*ADDR_W +: ADDR_W] != '0 && tilt_addr[i*ADDR_W +: ADDR_W] == request_addr) begin
        tilt_hit = 1'b1;
        tilt_val = cur_tilt[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    if (request_addr == '0)                    rd_val = c_start;
    else if (!({1'b0, request_addr} < c_universe)) rd_val = '0;
    else if (busy)                             rd_val = '0;
    else if (pan_hit)                          rd_val = pan_val;
    else if (tilt_hit)                         rd_val = tilt_val;
    else                                       rd_val = ram[request_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_valid <= 1'b0;
      addr_out   <= '0;
      data_out   <= '0;
    end else begin
      data_valid <= request_pulse;
      if (request_pulse) begin
        addr_out <= request_addr;
        data_out <= rd_val;
      end
    end
  end

  // Slew reads the pre-edge target, so a same-edge calc_ready only affects later ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      tgt_pan  <= {NUM_FIXTURES{c_park}};
      tgt_tilt <= {NUM_FIXTURES{c_park}};
      cur_pan  <= {NUM_FIXTURES{c_park}};
      cur_tilt <= {NUM_FIXTURES{c_park}};
    end else begin
      for (int i = 0; i < NUM_FIXTURES; i++) begin
        if (frame_tick) begin
          cur_pan[i*DATA_W +: DATA_W]  <= slew(cur_pan[i*DATA_W +: DATA_W],  tgt_pan[i*DATA_W +: DATA_W]);
          cur_tilt[i*DATA_W +: DATA_W] <= slew(cur_tilt[i*DATA_W +: DATA_W], tgt_tilt[i*DATA_W +: DATA_W]);
        end
        if (calc_ready[i]) begin
          tgt_pan[i*DATA_W +: DATA_W]  <= pan[i*DATA_W +: DATA_W];
          tgt_tilt[i*DATA_W +: DATA_W] <= tilt[i*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmx_universe_store.sv
`default_nettype none
// ============================================================================
// tb_dmx_universe_store : scoreboard bench for dmx_universe_store
// Revision: 1.0
// ============================================================================
module tb_dmx_universe_store;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  request_addr = '0;
  logic        request_pulse = 1'b0;
  logic [8:0]  addr_out;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        wr_en = 1'b0;
  logic [8:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic [17:0] pan_addr = '0;
  logic [17:0] tilt_addr = '0;
  logic [15:0] pan = '0;
  logic [15:0] tilt = '0;
  logic [1:0]  calc_ready = '0;
  logic        frame_tick = 1'b0;
  logic        busy;

  typedef struct packed {
    logic [8:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          errors = 0;
  int          checks = 0;
  logic        exp_dv = 1'b0;
  logic        rst_q = 1'b1;
  logic [8:0]  last_addr = '0;
  logic [7:0]  last_data = '0;

  dmx_universe_store #(
    .NUM_FIXTURES(2), .ADDR_W(9), .UNIVERSE(512), .DATA_W(8),
    .PARK_VALUE(128), .SLEW_STEP(4), .START_CODE(0)
  ) dut (
    .clk(clk), .reset(reset),
    .request_addr(request_addr), .request_pulse(request_pulse),
    .addr_out(addr_out), .data_out(data_out), .data_valid(data_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pan_addr(pan_addr), .tilt_addr(tilt_addr), .pan(pan), .tilt(tilt),
    .calc_ready(calc_ready), .frame_tick(frame_tick), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference for the one-cycle read strobe and reset of the output registers.
  always @(posedge clk) begin
    exp_dv <= request_pulse && !reset;
    rst_q  <= reset;
  end

  always @(negedge clk) begin
    if (rst_q) begin
      last_addr = '0;
      last_data = '0;
    end
    check("data_valid", data_valid, exp_dv);
    if (exp_dv) begin
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        check("addr_out", addr_out, e.addr);
        check("data_out", data_out, e.data);
        last_addr = e.addr;
        last_data = e.data;
      end
    end else begin
      check("addr_hold", addr_out, last_addr);
      check("data_hold", data_out, last_data);
    end
  end

  task automatic push(input logic [8:0] a, input logic [7:0] d);
    exp_t x;
    x.addr = a;
    x.data = d;
    sb.push_back(x);
  endtask

  task automatic req(input logic [8:0] a, input logic [7:0] d);
    request_addr  = a;
    request_pulse = 1'b1;
    push(a, d);
    @(negedge clk);
    request_pulse = 1'b0;
  endtask

  task automatic wr(input logic [8:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  // Reset, then measure how long busy stays high; optionally read slot 5 mid-clear.
  task automatic do_reset(input bit probe);
    int n = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      if (probe && n == 10) begin
        request_addr  = 9'd5;
        request_pulse = 1'b1;
        push(9'd5, 8'h00);
      end else begin
        request_pulse = 1'b0;
      end
      @(negedge clk);
    end
    request_pulse = 1'b0;
    check("busy_len", n, 512);
  endtask

  initial begin
    do_reset(1'b1);
    drain();

    wr(9'd2, 8'h55);
    req(9'd2, 8'h55);
    req(9'd0, 8'h00);
    drain();

    // Fixture 0 overlays pan on slot 1 and tilt on slot 9.
    pan_addr[8:0] = 9'd1; tilt_addr[8:0] = 9'd9;
    pan[7:0] = 8'h90; tilt[7:0] = 8'h02;
    calc_ready = 2'b01;
    @(negedge clk);
    calc_ready = 2'b00;
    wr(9'd1, 8'h33);
    req(9'd1, 8'h80);
    tick();
    req(9'd1, 8'h84);
    req(9'd9, 8'h7C);
    repeat (3) tick();
    req(9'd1, 8'h90);
    tick();
    req(9'd1, 8'h90);

    // Both fixtures on slot 7; calc_ready coincides with frame_tick.
    pan_addr = {9'd7, 9'd7};
    pan = {8'h82, 8'h7E};
    calc_ready = 2'b11;
    frame_tick = 1'b1;
    @(negedge clk);
    calc_ready = 2'b00;
    frame_tick = 1'b0;
    req(9'd7, 8'h90);
    tick();
    req(9'd7, 8'h8C);
    pan_addr[8:0] = 9'd0;
    req(9'd7, 8'h82);
    req(9'd1, 8'h33);
    req(9'd9, 8'h64);
    drain();

    // Read-first on a same-cycle read/write.
    wr(9'd4, 8'h22);
    wr_en = 1'b1; wr_addr = 9'd4; wr_data = 8'h11;
    request_addr = 9'd4; request_pulse = 1'b1;
    push(9'd4, 8'h22);
    @(negedge clk);
    wr_en = 1'b0; request_pulse = 1'b0;
    req(9'd4, 8'h11);
    drain();

    // Reset in RUN clears RAM and parks the fixtures.
    wr(9'd3, 8'hAA);
    req(9'd3, 8'hAA);
    drain();
    do_reset(1'b0);
    req(9'd3, 8'h00);
    pan_addr[8:0] = 9'd1;
    req(9'd1, 8'h80);
    req(9'd7, 8'h80);
    drain();

    // Reset in the middle of CLEAR restarts the full sweep.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    do_reset(1'b0);
    req(9'd2, 8'h00);
    drain();
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
